// File: rtl/keycode_move_ctrl.sv
// Keyboard-driven tile walker: decodes a registered HID keycode into
// facing/step commands and walks the player one tile per step, one
// pixel per frame_tick, with a one-cycle TURN for the map block check.
// Ports:
//   Clk, Reset          clock, async active-high reset
//   keycode[7:0]        HID keycode (0x00 = none)
//   frame_tick          one-cycle per-frame strobe
//   blocked             map answer for target_x/target_y (same cycle)
//   pos_x/pos_y[9:0]    sprite position in pixels
//   target_x/y[9:0]     tile entered for the current facing
//   facing[1:0]         0=up 1=down 2=left 3=right
//   moving              high while a step is in progress
//   walk_frame          toggles at each half-step
//   action_pulse        one-cycle pulse on an Enter press
module keycode_move_ctrl #(
   parameter int TILE   = 16,
   parameter int X_MAX  = 624,
   parameter int Y_MAX  = 464,
   parameter int X_INIT = 320,
   parameter int Y_INIT = 240
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       frame_tick,
   input  logic       blocked,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [9:0] target_x,
   output logic [9:0] target_y,
   output logic [1:0] facing,
   output logic       moving,
   output logic       walk_frame,
   output logic       action_pulse
);

   localparam int CW = $clog2(TILE) + 1;

   localparam logic [7:0] KC_W   = 8'h1A;
   localparam logic [7:0] KC_S   = 8'h16;
   localparam logic [7:0] KC_A   = 8'h04;
   localparam logic [7:0] KC_D   = 8'h07;
   localparam logic [7:0] KC_ENT = 8'h28;

   localparam logic [10:0] TILE11 = 11'(TILE);
   localparam logic [10:0] XMAX11 = 11'(X_MAX);
   localparam logic [10:0] YMAX11 = 11'(Y_MAX);
   localparam logic [CW-1:0] HALF = CW'(TILE / 2);
   localparam logic [CW-1:0] FULL = CW'(TILE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TURN,
      S_MOVE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    kc_q, kc_d;
   logic [9:0]    px_q, px_d;
   logic [9:0]    py_q, py_d;
   logic [1:0]    face_q, face_d;
   logic [1:0]    dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wf_q, wf_d;
   logic          act_q, act_d;

   logic          cmd_vld;
   logic [1:0]    cmd_dir;
   logic [10:0]   tx, ty;
   logic          in_bounds;
   logic [CW-1:0] cnt_nx;

   always_comb begin
      cmd_vld = 1'b1;
      cmd_dir = 2'd0;
      case (kc_q)
         KC_W:    cmd_dir = 2'd0;
         KC_S:    cmd_dir = 2'd1;
         KC_A:    cmd_dir = 2'd2;
         KC_D:    cmd_dir = 2'd3;
         default: cmd_vld = 1'b0;
      endcase
   end

   // 11-bit target: a step below zero wraps far above any legal max,
   // so one unsigned compare per axis catches both edges.
   always_comb begin
      tx = {1'b0, px_q};
      ty = {1'b0, py_q};
      case (face_q)
         2'd0:    ty = ty - TILE11;
         2'd1:    ty = ty + TILE11;
         2'd2:    tx = tx - TILE11;
         default: tx = tx + TILE11;
      endcase
      in_bounds = (tx <= XMAX11) && (ty <= YMAX11);
   end

   assign kc_d   = keycode;
   assign act_d  = (keycode == KC_ENT) && (kc_q != KC_ENT);
   assign cnt_nx = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      face_d  = face_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      wf_d    = wf_q;
      case (state_q)
         S_IDLE: begin
            if (frame_tick && cmd_vld) begin
               face_d  = cmd_dir;
               state_d = S_TURN;
            end
         end
         // Ticks landing here are dropped on purpose.
         S_TURN: begin
            if (!blocked && in_bounds) begin
               dir_d   = face_q;
               cnt_d   = '0;
               state_d = S_MOVE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MOVE: begin
            if (frame_tick) begin
               case (dir_q)
                  2'd0:    py_d = py_q - 10'd1;
                  2'd1:    py_d = py_q + 10'd1;
                  2'd2:    px_d = px_q - 10'd1;
                  default: px_d = px_q + 10'd1;
               endcase
               cnt_d = cnt_nx;
               if (cnt_nx == HALF || cnt_nx == FULL) begin
                  wf_d = ~wf_q;
               end
               if (cnt_nx == FULL) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         kc_q    <= 8'h00;
         px_q    <= 10'(X_INIT);
         py_q    <= 10'(Y_INIT);
         face_q  <= 2'd1;
         dir_q   <= 2'd1;
         cnt_q   <= '0;
         wf_q    <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kc_q    <= kc_d;
         px_q    <= px_d;
         py_q    <= py_d;
         face_q  <= face_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         wf_q    <= wf_d;
         act_q   <= act_d;
      end
   end

   assign pos_x        = px_q;
   assign pos_y        = py_q;
   assign target_x     = tx[9:0];
   assign target_y     = ty[9:0];
   assign facing       = face_q;
   assign moving       = (state_q == S_MOVE);
   assign walk_frame   = wf_q;
   assign action_pulse = act_q;

endmodule

// File: doc/keycode_move_ctrl.md
KEYCODE_MOVE_CTRL -- requirements
Module: keycode_move_ctrl

Interface
REQ-001 Parameter TILE, default 16, meaning pixels per walk step (power of two, 2..64).
REQ-002 Parameter X_MAX, default 624, meaning largest legal pos_x (pixels, multiple of TILE).
REQ-003 Parameter Y_MAX, default 464, meaning largest legal pos_y (pixels, multiple of TILE).
REQ-004 Parameter X_INIT, default 320, meaning pos_x after reset (multiple of TILE).
REQ-005 Parameter Y_INIT, default 240, meaning pos_y after reset (multiple of TILE).
REQ-006 Clk  input  1  sole clock; all state on rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 keycode  input  8  USB HID keycode from the SoC keycode export; 0x00 = no key.
REQ-009 frame_tick  input  1  one-Clk strobe, once per video frame (vsync start).
REQ-010 blocked  input  1  combinational map answer for target_x/target_y, valid same cycle.
REQ-011 pos_x  output  10  player sprite x, pixels.
REQ-012 pos_y  output  10  player sprite y, pixels.
REQ-013 target_x  output  10  x of tile the player would enter for current facing.
REQ-014 target_y  output  10  y of tile the player would enter for current facing.
REQ-015 facing  output  2  0=up,1=down,2=left,3=right.
REQ-016 moving  output  1  high while a step is in progress.
REQ-017 walk_frame  output  1  toggles at each completed half-step; drives sprite animation.
REQ-018 action_pulse  output  1  one-Clk pulse on action key press.

Function
REQ-019 Keycode decode: 0x1A=W->up, 0x16=S->down, 0x04=A->left, 0x07=D->right, 0x28=Enter->action; any other value = no command.
REQ-020 keycode shall be registered once (kc_q) before decode; decode uses kc_q only.
REQ-021 FSM states: IDLE, TURN, MOVE; encoding free.
REQ-022 IDLE, on frame_tick with a direction decoded: set facing to it, go TURN; no direction -> stay IDLE.
REQ-023 TURN (exactly one Clk): if blocked=0 and target in bounds -> latch step direction, clear step counter, go MOVE; else -> IDLE, position unchanged.
REQ-024 target_x/target_y = pos +/- TILE along facing, other axis equal pos; out-of-bounds (below 0 or above X_MAX/Y_MAX) detected with 11-bit arithmetic, not by wrap.
REQ-025 MOVE: on each frame_tick, pos moves 1 pixel along latched direction and step counter increments.
REQ-026 When step counter reaches TILE on a frame_tick, the step ends: pos is tile-aligned, go IDLE in the next Clk.
REQ-027 Direction keys and facing changes are ignored during MOVE; a held key produces back-to-back steps, one idle frame_tick between them.
REQ-028 walk_frame toggles when step counter reaches TILE/2 and when it reaches TILE.
REQ-029 moving = 1 exactly in MOVE.
REQ-030 action_pulse: high for one Clk when kc_q becomes 0x28 from any other value, in any state; held Enter gives no repeat.
REQ-031 frame_tick arriving in the TURN cycle is dropped, not queued.
REQ-032 pos_x/pos_y shall never leave [0, X_MAX] / [0, Y_MAX].

Reset
REQ-033 Reset asserted, at any time including mid-MOVE: state IDLE, pos_x=X_INIT, pos_y=Y_INIT, facing=1 (down), moving=0, walk_frame=0, action_pulse=0, kc_q=0x00, step counter=0.
REQ-034 After Reset deassertion, the first command is accepted on the first qualifying frame_tick.

Verification
REQ-035 keycode=0x07 held, blocked=0, 16 frame_ticks after TURN -> pos_x 320->336, moving high for 16 ticks, walk_frame toggles twice, pos_y=240.
REQ-036 pos_x=0, keycode=0x04 -> facing=2, TURN returns IDLE, pos_x stays 0, moving never high.
REQ-037 keycode=0x1A, blocked=1 -> facing=0, no step, pos_y stays 240.
REQ-038 keycode 0x00->0x28 held 100 Clk -> exactly one action_pulse; 0x28->0x00->0x28 -> second pulse.
REQ-039 Reset after 7 ticks of a right step -> pos_x=320, state IDLE, moving=0; resumed keycode 0x07 -> full 16-pixel step to 336.
REQ-040 keycode changes 0x07->0x16 mid-MOVE -> step finishes at pos_x=336, then next step goes down (pos_y 240->256).
